ice_status_frame_rx: RTL
========================

Name: ice_status_frame_rx

Overview:
Receives the byte stream from the UART receiver on the iCEboard RX line and assembles motor status frames. Each frame is CRC-checked. Fields from good frames are presented with a one-cycle valid strobe. The block sits between the UART byte receiver and the per-motor status registers (encoder positions, displacement, duty, current) that the Avalon slave reads. It also keeps link-quality counters for the communication-quality and CRC registers.

Parameters:
NUMBER_OF_MOTORS, 8, frames with motor id >= this value are dropped
CLOCK_FREQ_HZ, 50_000_000, clk frequency
BAUDRATE, 1_000_000, UART bit rate; one byte time = 10*CLOCK_FREQ_HZ/BAUDRATE cycles
TIMEOUT_BYTES, 4, inter-byte gap, in byte times, that aborts a frame in progress

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid
rx_frame_err  in  1  UART stop-bit error, qualified by rx_valid
status_valid  out  1  one-cycle strobe; a good frame was accepted
status_motor  out  8  motor id of the last good frame
encoder0_position  out  24  signed
encoder1_position  out  24  signed
displacement  out  24  signed
duty  out  24  signed
current  out  13  signed
crc_checksum  out  16  received CRC of the last good frame
frames_ok  out  32  count of good frames, saturating
frames_crc_err  out  32  count of CRC mismatches, saturating
frames_drop  out  32  count of id errors, framing errors and timeouts, saturating

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is synchronous and active-high.
  - Reset clears all outputs and counters to 0 and puts the FSM in HUNT.
- Frame format, 18 bytes, multi-byte fields MSB first:
  - SYNC 0xAA
  - ID (1 byte)
  - ENC0 (3), ENC1 (3), DISP (3), DUTY (3)
  - CUR (2): value in the low 13 bits; bits 15:13 are ignored
  - CRC (2)
- CRC:
  - CRC-16/CCITT: poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Computed over ID through CUR (15 bytes).
  - Updated one byte per rx_valid.
- FSM states: HUNT, PAYLOAD, CRC_HI, CRC_LO, CHECK.
  - HUNT: on rx_valid with rx_data == 0xAA and no framing error, go to PAYLOAD. Byte counter = 0, CRC = 0xFFFF. Other bytes are ignored and not counted.
  - PAYLOAD: each rx_valid stores the byte into a shift/field register and updates the CRC. After the 15th byte, go to CRC_HI.
  - CRC_HI: the next byte is stored as CRC[15:8]; go to CRC_LO.
  - CRC_LO: the next byte is stored as CRC[7:0]; go to CHECK.
  - CHECK: lasts exactly one cycle, then returns to HUNT.
- CHECK outcomes:
  - CRC mismatch: frames_crc_err += 1. Outputs are held.
  - CRC match and ID >= NUMBER_OF_MOTORS: frames_drop += 1. Outputs are held.
  - CRC match and ID valid: all field outputs and crc_checksum update, frames_ok += 1, status_valid = 1.
- Latency: status_valid and the updated fields appear 2 cycles after the rx_valid of the final CRC byte (one cycle into CHECK, one registered output cycle). Fields are stable until the next good frame.
- Timeout:
  - The gap counter runs outside HUNT and is cleared by every rx_valid.
  - When it reaches TIMEOUT_BYTES*10*CLOCK_FREQ_HZ/BAUDRATE: frames_drop += 1, go to HUNT.
  - If rx_valid arrives in the same cycle the counter reaches the limit, the byte wins and there is no timeout.
- Framing error: rx_valid with rx_frame_err outside HUNT aborts the frame, frames_drop += 1, go to HUNT. The byte is discarded even if it is 0xAA.
- 0xAA inside a frame is treated as data; the block does not resynchronise mid-frame.
- Counters saturate at 0xFFFFFFFF and never wrap.
- The field outputs drive the slave's current[12:0] and 24-bit registers directly, with no width conversion.
- Reset mid-frame: the frame is lost; the next SYNC byte starts fresh.

Decomposition:
- Shared package ice_coms_pkg:
  - SYNC_BYTE = 8'hAA, FRAME_PAYLOAD_BYTES = 15, CRC_POLY = 16'h1021, CRC_INIT = 16'hFFFF
  - FSM state enum
  - Field offset constants
  - Packed struct status_frame_t (id, enc0, enc1, disp, duty, cur)
- Sub-module crc16_ccitt_byte: combinational next-CRC from (crc_in, byte). It is reused by the TX frame builder in coms.

Test Plan:
- Good frame, with CRC from the bench model: ID = 3, ENC0 = 0x000100, ENC1 = 0xFFFFFF, DISP = 0x7FFFFF, DUTY = 0x800000, CUR = 0x1FFF -> status_valid once, 2 cycles after the last byte. Outputs status_motor = 3, encoder1_position = -1, displacement = 8388607, duty = -8388608, current = -1, frames_ok = 1.
- Same frame with CRC low byte XOR 0x01 -> no status_valid, frames_crc_err = 1, outputs unchanged from the previous frame.
- Garbage bytes 0x00, 0x55, 0x12 followed by a good frame for ID = 7 -> accepted, frames_drop = 0.
- Valid CRC with ID = 8 -> frames_drop = 1, no status_valid.
- Timeout:
  - Stop after 5 bytes for one timeout period plus 1 cycle, then send a full good frame -> frames_drop = 1, second frame accepted.
  - rx_valid on exactly the limit cycle -> no timeout.
- rx_frame_err on byte 9 -> frames_drop = 1, FSM in HUNT.
- Back-to-back good frames with zero gap -> two status_valid strobes.
- reset asserted mid-frame -> all outputs 0, next frame accepted.

Source files
------------

// File: rtl/ice_coms_pkg.sv
// Shared constants, types and helpers for the iCEboard motor status link.
package ice_coms_pkg;

    localparam logic [7:0]  SYNC_BYTE           = 8'hAA;
    localparam int unsigned FRAME_PAYLOAD_BYTES = 15;
    localparam int unsigned FRAME_BITS          = FRAME_PAYLOAD_BYTES * 8;
    localparam logic [15:0] CRC_POLY            = 16'h1021;
    localparam logic [15:0] CRC_INIT            = 16'hFFFF;
    localparam int unsigned CUR_W               = 13;

    // Byte offsets of each field within the CRC-covered payload (ID is byte 0)
    localparam int unsigned OFF_ID   = 0;
    localparam int unsigned OFF_ENC0 = 1;
    localparam int unsigned OFF_ENC1 = 4;
    localparam int unsigned OFF_DISP = 7;
    localparam int unsigned OFF_DUTY = 10;
    localparam int unsigned OFF_CUR  = 13;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CRC_HI  = 3'd2,
        ST_CRC_LO  = 3'd3,
        ST_CHECK   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic [7:0]  id;
        logic [23:0] enc0;
        logic [23:0] enc1;
        logic [23:0] disp;
        logic [23:0] duty;
        logic [15:0] cur;
    } status_frame_t;

    // Payload is shifted in MSB first, so byte 0 sits at the top of the vector
    function automatic status_frame_t unpack_frame(input logic [FRAME_BITS-1:0] raw);
        status_frame_t f;
        f.id   = raw[FRAME_BITS-1-8*OFF_ID   -: 8];
        f.enc0 = raw[FRAME_BITS-1-8*OFF_ENC0 -: 24];
        f.enc1 = raw[FRAME_BITS-1-8*OFF_ENC1 -: 24];
        f.disp = raw[FRAME_BITS-1-8*OFF_DISP -: 24];
        f.duty = raw[FRAME_BITS-1-8*OFF_DUTY -: 24];
        f.cur  = raw[FRAME_BITS-1-8*OFF_CUR  -: 16];
        return f;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16/CCITT update by one byte, MSB first, no reflection.
module crc16_ccitt_byte
    import ice_coms_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc_c
);

    logic [15:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {i_data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[15] ? ({w_crc[14:0], 1'b0} ^ CRC_POLY) : {w_crc[14:0], 1'b0};
        end
        o_crc_c = w_crc;
    end

endmodule

// File: rtl/ice_status_frame_rx.sv
// Assembles 18-byte motor status frames from the UART byte stream, CRC-checks
// them, publishes good frames and keeps saturating link-quality counters.
module ice_status_frame_rx
    import ice_coms_pkg::*;
#(
    parameter int unsigned NUMBER_OF_MOTORS = 8,
    parameter int unsigned CLOCK_FREQ_HZ    = 50_000_000,
    parameter int unsigned BAUDRATE         = 1_000_000,
    parameter int unsigned TIMEOUT_BYTES    = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_frame_err,
    output logic               status_valid,
    output logic [7:0]         status_motor,
    output logic signed [23:0] encoder0_position,
    output logic signed [23:0] encoder1_position,
    output logic signed [23:0] displacement,
    output logic signed [23:0] duty,
    output logic signed [12:0] current,
    output logic [15:0]        crc_checksum,
    output logic [31:0]        frames_ok,
    output logic [31:0]        frames_crc_err,
    output logic [31:0]        frames_drop
);

    localparam int unsigned BYTE_CYCLES    = 10 * CLOCK_FREQ_HZ / BAUDRATE;
    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * BYTE_CYCLES;
    localparam int unsigned GAP_W          = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_e             r_state;
    rx_state_e             w_state_nxt;
    logic [3:0]            r_byte_cnt;
    logic [15:0]           r_crc;
    logic [15:0]           r_rx_crc;
    logic [FRAME_BITS-1:0] r_shift;
    logic [GAP_W-1:0]      r_gap;

    logic                  w_in_frame;
    logic                  w_byte_ok;
    logic                  w_start;
    logic                  w_last_payload;
    logic                  w_timeout;
    logic                  w_abort;
    logic                  w_crc_match;
    logic                  w_id_ok;
    logic [15:0]           w_crc_nxt;
    status_frame_t         w_frame;
    logic                  w_unused_cur_hi;

    crc16_ccitt_byte u_crc (
        .i_crc   (r_crc),
        .i_data  (rx_data),
        .o_crc_c (w_crc_nxt)
    );

    assign w_frame         = unpack_frame(r_shift);
    assign w_unused_cur_hi = ^w_frame.cur[15:CUR_W];

    always_comb begin
        w_in_frame     = (r_state == ST_PAYLOAD) || (r_state == ST_CRC_HI) || (r_state == ST_CRC_LO);
        w_byte_ok      = rx_valid && !rx_frame_err;
        // CHECK accepts a new SYNC like HUNT so zero-gap frames are not lost
        w_start        = ((r_state == ST_HUNT) || (r_state == ST_CHECK)) && w_byte_ok
                         && (rx_data == SYNC_BYTE);
        w_last_payload = (r_byte_cnt == 4'(FRAME_PAYLOAD_BYTES - 1));
        w_abort        = w_in_frame && rx_valid && rx_frame_err;
        // A byte arriving on the limit cycle takes priority over the timeout
        w_timeout      = w_in_frame && !rx_valid && (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));
        w_crc_match    = (r_crc == r_rx_crc);
        w_id_ok        = (32'(w_frame.id) < NUMBER_OF_MOTORS);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT, ST_CHECK: w_state_nxt = w_start ? ST_PAYLOAD : ST_HUNT;
            ST_PAYLOAD: if (w_byte_ok && w_last_payload) w_state_nxt = ST_CRC_HI;
            ST_CRC_HI:  if (w_byte_ok) w_state_nxt = ST_CRC_LO;
            ST_CRC_LO:  if (w_byte_ok) w_state_nxt = ST_CHECK;
            default:    w_state_nxt = ST_HUNT;
        endcase
        if (w_abort || w_timeout) begin
            w_state_nxt = ST_HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath: gap timer, byte counter, running CRC, payload shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_crc      <= CRC_INIT;
            r_rx_crc   <= '0;
            r_shift    <= '0;
            r_gap      <= '0;
        end else begin
            if (!w_in_frame || rx_valid) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + GAP_W'(1);
            end

            if (w_start) begin
                r_byte_cnt <= '0;
                r_crc      <= CRC_INIT;
            end

            if (w_byte_ok) begin
                case (r_state)
                    ST_PAYLOAD: begin
                        r_shift    <= {r_shift[FRAME_BITS-9:0], rx_data};
                        r_crc      <= w_crc_nxt;
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                    ST_CRC_HI: r_rx_crc[15:8] <= rx_data;
                    ST_CRC_LO: r_rx_crc[7:0]  <= rx_data;
                    default: ;
                endcase
            end
        end
    end

    // Outputs and link-quality counters
    always_ff @(posedge clk) begin
        if (reset) begin
            status_valid      <= 1'b0;
            status_motor      <= '0;
            encoder0_position <= '0;
            encoder1_position <= '0;
            displacement      <= '0;
            duty              <= '0;
            current           <= '0;
            crc_checksum      <= '0;
            frames_ok         <= '0;
            frames_crc_err    <= '0;
            frames_drop       <= '0;
        end else begin
            status_valid <= 1'b0;
            if (r_state == ST_CHECK) begin
                if (!w_crc_match) begin
                    frames_crc_err <= sat_inc(frames_crc_err);
                end else if (!w_id_ok) begin
                    frames_drop <= sat_inc(frames_drop);
                end else begin
                    status_valid      <= 1'b1;
                    status_motor      <= w_frame.id;
                    encoder0_position <= w_frame.enc0;
                    encoder1_position <= w_frame.enc1;
                    displacement      <= w_frame.disp;
                    duty              <= w_frame.duty;
                    current           <= w_frame.cur[CUR_W-1:0];
                    crc_checksum      <= r_rx_crc;
                    frames_ok         <= sat_inc(frames_ok);
                end
            end
            if (w_abort || w_timeout) begin
                frames_drop <= sat_inc(frames_drop);
            end
        end
    end

endmodule
